ahb_lite_decode_mux: RTL
========================

// Module: ahb_lite_decode_mux
// PURPOSE
//  Parametrised AHB-Lite interconnect for a single master and NUM_SLAVES slaves.
//  - Decodes HADDR into one-hot HSEL.
//  - Tracks the data-phase owner, muxes slave responses back to the master.
//  - Built-in default slave answers unmapped active transfers with a two-cycle ERROR.
//  - Counts errors. Sits between the master and the slave array.
// PARAMETERS
//  NUM_SLAVES    4   number of mapped slaves (1..16)
//  DATAWIDTH     32  HRDATA width
//  ADDRWIDTH     32  HADDR width
//  SEL_BITS      4   region index = HADDR[ADDRWIDTH-1 -: SEL_BITS]; region >= NUM_SLAVES is unmapped
//  ERR_CNT_WIDTH 8   width of the saturating error counter
// PORTS
//  HCLK        in   1                     bus clock; all state on rising edge
//  HRESET      in   1                     synchronous, active-high reset
//  HADDR       in   ADDRWIDTH             master address (address phase)
//  HTRANS      in   2                     IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HSEL        out  NUM_SLAVES            one-hot slave select, combinational from HADDR
//  HRDATA_S    in   NUM_SLAVES*DATAWIDTH  slave read data; slave i at [i*DATAWIDTH +: DATAWIDTH]
//  HREADYOUT_S in   NUM_SLAVES            per-slave HREADYOUT
//  HRESP_S     in   NUM_SLAVES            per-slave HRESP (1 = ERROR)
//  HRDATA      out  DATAWIDTH             muxed read data to master
//  HREADY      out  1                     muxed ready; fed to master and all slaves
//  HRESP       out  1                     muxed response
//  err_count   out  ERR_CNT_WIDTH         default-slave errors since reset, saturating
// BEHAVIOUR
//  Address decode (combinational)
//   - HSEL[r] = 1 when region r < NUM_SLAVES; all zero when unmapped.
//   - HSEL does not depend on HTRANS.
//  Data-phase select register
//   - dsel = {is_default, index}, loaded only when HREADY==1.
//   - Captures the decoded region of the current address phase.
//   - Holds while HREADY==0 (wait states extend the data phase).
//  Response mux
//   - dsel = slave i: HRDATA = HRDATA_S[i], HREADY = HREADYOUT_S[i], HRESP = HRESP_S[i].
//   - dsel = default: HRDATA = 0; HREADY and HRESP come from the default-slave FSM.
//  Default-slave FSM: DS_OK -> DS_ERR1 -> DS_ERR2
//   - DS_OK: HREADY=1, HRESP=0.
//     -> DS_ERR1 when HREADY==1 and HTRANS[1]==1 and unmapped.
//   - DS_ERR1: HREADY=0, HRESP=1. Always -> DS_ERR2.
//   - DS_ERR2: HREADY=1, HRESP=1.
//     -> DS_ERR1 if another unmapped NONSEQ/SEQ is sampled in this cycle, else -> DS_OK.
//   - IDLE or BUSY to an unmapped address: zero-wait OKAY (stays DS_OK).
//   - Mapped slaves see no effect: their HSEL is 0 for unmapped addresses.
//  Error counter
//   - err_count += 1 on each entry to DS_ERR1.
//   - Saturates at all-ones; no wrap.
//  Latency
//   - HSEL: 0 cycles.
//   - Data-phase mux: 1 cycle after the address phase completes.
//  Reset (HRESET==1 at posedge), including mid-transfer or in DS_ERR1
//   - Next cycle: dsel = default, FSM = DS_OK, err_count = 0.
//   - Outputs: HREADY=1, HRESP=0, HRDATA=0.
//   - A pending error response is dropped.
// TESTING (NUM_SLAVES=4, SEL_BITS=4, ADDRWIDTH=32)
//  1. HADDR=0x2000_0010 NONSEQ, HREADYOUT_S=4'b1111, HRDATA_S[2]=0xCAFE_F00D
//     -> HSEL=4'b0100 same cycle; next cycle HRDATA=0xCAFE_F00D, HREADY=1, HRESP=0.
//  2. Slave 1 inserts 3 wait states (HREADYOUT_S[1]=0 x3) while master presents 0x3000_0000
//     -> HREADY=0 for 3 cycles, dsel stays 1, then switches to slave 3.
//  3. HADDR=0x5000_0000 NONSEQ
//     -> HSEL=0; next 2 cycles {HREADY,HRESP} = {0,1} then {1,1}; err_count=1.
//  4. HADDR=0x9000_0000 with HTRANS=IDLE -> HREADY=1, HRESP=0, err_count unchanged.
//  5. Back-to-back unmapped NONSEQ, 2nd sampled in DS_ERR2
//     -> pattern ERR1, ERR2, ERR1, ERR2; err_count=2.
//     ERR_CNT_WIDTH=2: 5 errors -> err_count=3.
//  6. Assert HRESET in DS_ERR1 -> next cycle HREADY=1, HRESP=0, err_count=0, FSM=DS_OK.

Source files
------------

// File: rtl/ahb_lite_decode_mux_if.sv
// AHB-Lite bus bundle between one master, the decode/mux block and the slave array.
// The "slave" modport is the interconnect's view; "master" is the surrounding
// environment (master plus slave array) that drives requests and slave responses.
interface ahb_lite_decode_mux_if #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned DATAWIDTH  = 32,
    parameter int unsigned ADDRWIDTH  = 32
);
    logic [ADDRWIDTH-1:0]            HADDR;
    logic [1:0]                      HTRANS;
    logic [NUM_SLAVES-1:0]           HSEL;
    logic [NUM_SLAVES*DATAWIDTH-1:0] HRDATA_S;
    logic [NUM_SLAVES-1:0]           HREADYOUT_S;
    logic [NUM_SLAVES-1:0]           HRESP_S;
    logic [DATAWIDTH-1:0]            HRDATA;
    logic                            HREADY;
    logic                            HRESP;

    modport slave (
        input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HSEL, HRDATA, HREADY, HRESP
    );

    modport master (
        output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HSEL, HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_decode_mux.sv
// AHB-Lite single-master decoder and response mux with a built-in default slave.
// Unmapped active transfers get a two-cycle ERROR; such errors are counted
// in a saturating counter.
module ahb_lite_decode_mux #(
    parameter int unsigned NUM_SLAVES    = 4,
    parameter int unsigned DATAWIDTH     = 32,
    parameter int unsigned ADDRWIDTH     = 32,
    parameter int unsigned SEL_BITS      = 4,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    ahb_lite_decode_mux_if.slave     bus,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        DS_OK   = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    localparam logic [SEL_BITS:0] NUM_SLAVES_W = (SEL_BITS + 1)'(NUM_SLAVES);

    logic [SEL_BITS-1:0]      region;
    logic                     mapped;
    logic [NUM_SLAVES-1:0]    hsel;
    logic [DATAWIDTH-1:0]     hrdata;
    logic                     hready;
    logic                     hresp;
    logic                     active_unmapped;
    logic                     unused_bus_bits;

    ds_state_e                state_q, state_d;
    logic                     dsel_def_q, dsel_def_d;
    logic [SEL_BITS-1:0]      dsel_idx_q, dsel_idx_d;
    logic                     ds_ready_q, ds_ready_d;
    logic                     ds_resp_q, ds_resp_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

    assign region          = bus.HADDR[ADDRWIDTH-1 -: SEL_BITS];
    assign mapped          = ({1'b0, region} < NUM_SLAVES_W);
    assign unused_bus_bits = &{1'b0, bus.HADDR[ADDRWIDTH-SEL_BITS-1:0], bus.HTRANS[0]};

    // Address decode: one-hot select from the region field, independent of HTRANS.
    always_comb begin
        hsel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (region == SEL_BITS'(i)) begin
                hsel[i] = 1'b1;
            end
        end
    end

    // Response mux: route the data-phase owner's response back to the master.
    always_comb begin
        hrdata = '0;
        hready = ds_ready_q;
        hresp  = ds_resp_q;
        if (!dsel_def_q) begin
            hready = 1'b1;
            hresp  = 1'b0;
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                if (dsel_idx_q == SEL_BITS'(i)) begin
                    hrdata = bus.HRDATA_S[i*DATAWIDTH +: DATAWIDTH];
                    hready = bus.HREADYOUT_S[i];
                    hresp  = bus.HRESP_S[i];
                end
            end
        end
    end

    // Next-state: data-phase owner, default-slave FSM, its registered outputs and the error count.
    always_comb begin
        active_unmapped = hready && bus.HTRANS[1] && !mapped;

        dsel_def_d = dsel_def_q;
        dsel_idx_d = dsel_idx_q;
        if (hready) begin
            dsel_def_d = !mapped;
            dsel_idx_d = region;
        end

        state_d = state_q;
        case (state_q)
            DS_OK:   state_d = active_unmapped ? DS_ERR1 : DS_OK;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = active_unmapped ? DS_ERR1 : DS_OK;
            default: state_d = DS_OK;
        endcase

        // ERR1 is never re-entered from itself, so landing there is always a new error.
        err_d = err_q;
        if (state_d == DS_ERR1 && err_q != '1) begin
            err_d = err_q + 1'b1;
        end

        ds_ready_d = 1'b1;
        ds_resp_d  = 1'b0;
        case (state_d)
            DS_ERR1: begin
                ds_ready_d = 1'b0;
                ds_resp_d  = 1'b1;
            end
            DS_ERR2: begin
                ds_ready_d = 1'b1;
                ds_resp_d  = 1'b1;
            end
            default: begin
                ds_ready_d = 1'b1;
                ds_resp_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any pending error response.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= DS_OK;
            dsel_def_q <= 1'b1;
            dsel_idx_q <= '0;
            ds_ready_q <= 1'b1;
            ds_resp_q  <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            dsel_def_q <= dsel_def_d;
            dsel_idx_q <= dsel_idx_d;
            ds_ready_q <= ds_ready_d;
            ds_resp_q  <= ds_resp_d;
            err_q      <= err_d;
        end
    end

    assign bus.HSEL   = hsel;
    assign bus.HRDATA = hrdata;
    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign err_count  = err_q;

endmodule
